// File: rtl/sorting.sv
// Packet sorter for an Avalon-ST style datapath.
// Captures one packet of up to MAX_PKT_LEN words, sorts the words in
// ascending unsigned order with an odd-even transposition network, then
// streams them out with sop/eop framing. One packet is in flight at a time.
module sorting #(
    parameter int DWIDTH      = 64,
    parameter int MAX_PKT_LEN = 128
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i
);

    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = $clog2(MAX_PKT_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_SORT = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    // Packet storage; contents are don't-care outside a packet.
    logic [DWIDTH-1:0] mem_q [MAX_PKT_LEN];
    logic [DWIDTH-1:0] mem_d [MAX_PKT_LEN];

    // Control state
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     ph_q, ph_d;          // sort phase counter
    logic [1:0]        quiet_q, quiet_d;    // consecutive phases without a swap
    logic [CW-1:0]     idx_q, idx_d;        // next word to present in SEND
    logic              snk_ready_q, snk_ready_d;
    logic [DWIDTH-1:0] src_data_q, src_data_d;
    logic              src_sop_q, src_sop_d;
    logic              src_eop_q, src_eop_d;
    logic              src_valid_q, src_valid_d;

    // Datapath control from the FSM
    logic              wr_en;
    logic [CW-1:0]     wr_idx;
    logic              sort_step;
    logic [AW-1:0]     rd_addr;
    logic [DWIDTH-1:0] rd_data;
    logic [MAX_PKT_LEN-2:0] swap_w;
    logic              any_swap;

    // Single read port: word 0 when leaving SORT, the next word while sending.
    assign rd_addr = (state_q == ST_SEND) ? AW'(idx_q) : '0;
    assign rd_data = mem_q[rd_addr];
    assign any_swap = |swap_w;

    // Pair (gi, gi+1) takes part in the current phase when its left index has
    // the phase parity and both words belong to the packet.
    for (genvar gi = 0; gi < MAX_PKT_LEN - 1; gi++) begin : g_pair
        assign swap_w[gi] = sort_step
                          && (ph_q[0] == 1'(gi % 2))
                          && (CW'(gi + 1) < count_q)
                          && (mem_q[gi + 1] < mem_q[gi]);
    end

    // Next value of each storage word: input write, or swap with a neighbour.
    // Pairs active in one phase are disjoint, so at most one swap hits a word.
    for (genvar gi = 0; gi < MAX_PKT_LEN; gi++) begin : g_elem
        logic wr_hit;
        assign wr_hit = wr_en && (wr_idx == CW'(gi));
        if (gi == 0) begin : g_first
            assign mem_d[gi] = wr_hit      ? snk_data_i :
                               swap_w[gi]  ? mem_q[gi + 1] : mem_q[gi];
        end else if (gi == MAX_PKT_LEN - 1) begin : g_last
            assign mem_d[gi] = wr_hit         ? snk_data_i :
                               swap_w[gi - 1] ? mem_q[gi - 1] : mem_q[gi];
        end else begin : g_mid
            assign mem_d[gi] = wr_hit         ? snk_data_i :
                               swap_w[gi]     ? mem_q[gi + 1] :
                               swap_w[gi - 1] ? mem_q[gi - 1] : mem_q[gi];
        end
    end

    // Storage update; no reset because stale words are never read.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < MAX_PKT_LEN; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // FSM next-state, capture, sort sequencing and output staging.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ph_d        = ph_q;
        quiet_d     = quiet_q;
        idx_d       = idx_q;
        snk_ready_d = snk_ready_q;
        src_data_d  = src_data_q;
        src_sop_d   = src_sop_q;
        src_eop_d   = src_eop_q;
        src_valid_d = src_valid_q;
        wr_en       = 1'b0;
        wr_idx      = count_q;
        sort_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a start-of-packet beat opens a packet; others are dropped.
                if (snk_valid_i && snk_startofpacket_i) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    count_d = CW'(1);
                    if (snk_endofpacket_i) begin
                        state_d     = ST_SORT;
                        ph_d        = '0;
                        quiet_d     = '0;
                        snk_ready_d = 1'b0;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                if (snk_valid_i) begin
                    wr_en = 1'b1;
                    if (snk_startofpacket_i) begin
                        // A new sop abandons the partial packet and restarts it.
                        wr_idx  = '0;
                        count_d = CW'(1);
                        if (snk_endofpacket_i) begin
                            state_d     = ST_SORT;
                            ph_d        = '0;
                            quiet_d     = '0;
                            snk_ready_d = 1'b0;
                        end
                    end else begin
                        wr_idx  = count_q;
                        count_d = count_q + CW'(1);
                        // Explicit eop, or the buffer is full (forced end).
                        if (snk_endofpacket_i || (count_q == CW'(MAX_PKT_LEN - 1))) begin
                            state_d     = ST_SORT;
                            ph_d        = '0;
                            quiet_d     = '0;
                            snk_ready_d = 1'b0;
                        end
                    end
                end
            end

            ST_SORT: begin
                // N phases always suffice; two quiet phases in a row mean the
                // packet is already ordered.
                if ((ph_q == count_q) || (quiet_q == 2'd2)) begin
                    src_data_d  = rd_data;
                    src_sop_d   = 1'b1;
                    src_eop_d   = (count_q == CW'(1));
                    src_valid_d = 1'b1;
                    idx_d       = CW'(1);
                    state_d     = ST_SEND;
                end else begin
                    sort_step = 1'b1;
                    ph_d      = ph_q + CW'(1);
                    if (any_swap) begin
                        quiet_d = '0;
                    end else if (quiet_q != 2'd2) begin
                        quiet_d = quiet_q + 2'd1;
                    end
                end
            end

            default: begin
                // ST_SEND: advance only on a handshake; hold otherwise.
                if (src_ready_i) begin
                    if (src_eop_q) begin
                        src_valid_d = 1'b0;
                        src_sop_d   = 1'b0;
                        src_eop_d   = 1'b0;
                        snk_ready_d = 1'b1;
                        count_d     = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        src_data_d = rd_data;
                        src_sop_d  = 1'b0;
                        src_eop_d  = (idx_q == count_q - CW'(1));
                        idx_d      = idx_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            ph_q        <= '0;
            quiet_q     <= '0;
            idx_q       <= '0;
            snk_ready_q <= 1'b1;
            src_data_q  <= '0;
            src_sop_q   <= 1'b0;
            src_eop_q   <= 1'b0;
            src_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ph_q        <= ph_d;
            quiet_q     <= quiet_d;
            idx_q       <= idx_d;
            snk_ready_q <= snk_ready_d;
            src_data_q  <= src_data_d;
            src_sop_q   <= src_sop_d;
            src_eop_q   <= src_eop_d;
            src_valid_q <= src_valid_d;
        end
    end

    assign snk_ready_o         = snk_ready_q;
    assign src_data_o          = src_data_q;
    assign src_startofpacket_o = src_sop_q;
    assign src_endofpacket_o   = src_eop_q;
    assign src_valid_o         = src_valid_q;

endmodule

// File: tb/tb_sorting.sv
// Self-checking bench for the packet sorter. Expected output is the input
// packet sorted with a queue sort; the bench drives and samples on negedges.
module tb_sorting;

    localparam int DW = 64;
    localparam int ML = 128;

    typedef logic [DW-1:0] word_t;

    logic          clk = 1'b0;
    logic          srst;
    word_t         snk_data;
    logic          snk_sop, snk_eop, snk_valid;
    logic          snk_ready_o;
    word_t         src_data_o;
    logic          src_sop_o, src_eop_o, src_valid_o;
    logic          src_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sorting #(.DWIDTH(DW), .MAX_PKT_LEN(ML)) dut (
        .clk_i               (clk),
        .srst_i              (srst),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid),
        .snk_ready_o         (snk_ready_o),
        .src_data_o          (src_data_o),
        .src_startofpacket_o (src_sop_o),
        .src_endofpacket_o   (src_eop_o),
        .src_valid_o         (src_valid_o),
        .src_ready_i         (src_ready)
    );

    task automatic idle_inputs();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_data  = '0;
    endtask

    // Drive one beat at the current negedge; returns at the next negedge.
    task automatic drive_beat(input word_t d, input logic sop, input logic eop);
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        @(negedge clk);
        idle_inputs();
    endtask

    // Send a packet; gap_pct is the chance of an idle cycle before each beat.
    task automatic send_pkt(input word_t w[$], input int gap_pct, input bit use_eop, input string name);
        for (int i = 0; i < w.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                snk_valid = 1'b0;
                snk_sop   = 1'b0;
                snk_eop   = 1'b0;
                snk_data  = {$urandom(), $urandom()};
                @(negedge clk);
            end
            total++;
            if (snk_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL %s snk_ready beat %0d: got %b want 1", name, i, snk_ready_o);
            end
            snk_valid = 1'b1;
            snk_data  = w[i];
            snk_sop   = (i == 0);
            snk_eop   = use_eop && (i == w.size() - 1);
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // Entered at the first negedge after the last input beat was accepted.
    task automatic recv_pkt(input word_t exp_q[$], input bit stall, input string name);
        int n     = exp_q.size();
        int bound = 2 * n * n + 2;
        int c     = 1;
        logic [DW+2:0] got, want;
        while (src_valid_o !== 1'b1 && c <= bound + 8) begin
            total++;
            if (snk_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_ready cycle %0d: got %b want 0", name, c, snk_ready_o);
            end
            @(negedge clk);
            c++;
        end
        total++;
        if (src_valid_o !== 1'b1 || c > bound) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles (valid=%b) want <= %0d", name, c, src_valid_o, bound);
        end
        if (src_valid_o !== 1'b1) return;
        for (int k = 0; k < n; k++) begin
            want = {1'b1, (k == 0), (k == n - 1), exp_q[k]};
            got  = {src_valid_o, src_sop_o, src_eop_o, src_data_o};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s beat %0d {v,sop,eop,data}: got %h want %h", name, k, got, want);
            end
            total++;
            if (snk_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL %s send_ready beat %0d: got %b want 0", name, k, snk_ready_o);
            end
            if (stall && k == n / 2) begin
                src_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    got = {src_valid_o, src_sop_o, src_eop_o, src_data_o};
                    total++;
                    if (got !== want) begin
                        bad++;
                        $display("FAIL %s hold beat %0d: got %h want %h", name, k, got, want);
                    end
                end
                src_ready = 1'b1;
            end
            @(negedge clk);
        end
        total++;
        if (src_valid_o !== 1'b0 || snk_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL %s after_eop {valid,ready}: got %b%b want 01", name, src_valid_o, snk_ready_o);
        end
    endtask

    task automatic test_reset();
        srst = 1'b0;
        src_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        total++;
        if (snk_ready_o !== 1'b1) begin bad++; $display("FAIL reset snk_ready: got %b want 1", snk_ready_o); end
        total++;
        if (src_valid_o !== 1'b0) begin bad++; $display("FAIL reset src_valid: got %b want 0", src_valid_o); end
        total++;
        if (src_sop_o !== 1'b0 || src_eop_o !== 1'b0) begin
            bad++; $display("FAIL reset sop/eop: got %b%b want 00", src_sop_o, src_eop_o);
        end
        total++;
        if (src_data_o !== '0) begin bad++; $display("FAIL reset src_data: got %h want 0", src_data_o); end
        srst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_descending();
        word_t w[$], e[$];
        for (int i = 10; i >= 1; i--) w.push_back(word_t'(i));
        for (int i = 1; i <= 10; i++) e.push_back(word_t'(i));
        send_pkt(w, 0, 1'b1, "descending");
        recv_pkt(e, 1'b0, "descending");
    endtask

    task automatic test_sorted();
        word_t w[$];
        for (int i = 0; i < 10; i++) w.push_back(word_t'(i));
        send_pkt(w, 0, 1'b1, "presorted");
        recv_pkt(w, 1'b0, "presorted");
    endtask

    task automatic test_single();
        word_t w[$];
        w.push_back(64'hDEADBEEF);
        send_pkt(w, 0, 1'b1, "single");
        recv_pkt(w, 1'b0, "single");
    endtask

    // Beat without sop in IDLE is dropped; a second sop restarts the packet.
    task automatic test_restart_drop();
        word_t e[$];
        e.push_back(64'd10); e.push_back(64'd20); e.push_back(64'd30);
        drive_beat(64'd0, 1'b0, 1'b0);
        drive_beat(64'd100, 1'b1, 1'b0);
        drive_beat(64'd200, 1'b0, 1'b0);
        drive_beat(64'd30, 1'b1, 1'b0);
        drive_beat(64'd20, 1'b0, 1'b0);
        drive_beat(64'd10, 1'b0, 1'b1);
        recv_pkt(e, 1'b0, "restart");
    endtask

    task automatic test_duplicates_backpressure();
        word_t w[$], e[$];
        w.push_back(64'd5); w.push_back(64'd5); w.push_back(64'd0); w.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        e.push_back(64'd0); e.push_back(64'd5); e.push_back(64'd5); e.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        send_pkt(w, 0, 1'b1, "dups");
        recv_pkt(e, 1'b1, "dups");
    endtask

    task automatic test_forced_eop();
        word_t w[$], e[$];
        for (int i = 0; i < ML; i++) w.push_back({$urandom(), $urandom()});
        e = w;
        e.sort();
        send_pkt(w, 0, 1'b0, "forced_eop");
        recv_pkt(e, 1'b0, "forced_eop");
    endtask

    task automatic test_all_lengths();
        for (int len = 1; len <= ML; len++) begin
            word_t w[$], e[$];
            for (int i = 0; i < len; i++) w.push_back({$urandom(), $urandom()});
            e = w;
            e.sort();
            send_pkt(w, 0, 1'b1, $sformatf("len%0d", len));
            recv_pkt(e, 1'b0, $sformatf("len%0d", len));
        end
    endtask

    task automatic test_random_packets();
        for (int p = 0; p < 100; p++) begin
            word_t w[$], e[$];
            int len = $urandom_range(ML, 1);
            for (int i = 0; i < len; i++) w.push_back({$urandom(), $urandom()});
            e = w;
            e.sort();
            send_pkt(w, 50, 1'b1, $sformatf("rand%0d", p));
            recv_pkt(e, 1'b0, $sformatf("rand%0d", p));
        end
    endtask

    // Asynchronous reset during SEND abandons the packet immediately.
    task automatic test_reset_mid();
        word_t w[$], e[$];
        int c = 0;
        w.push_back(64'd9); w.push_back(64'd7); w.push_back(64'd8); w.push_back(64'd6);
        send_pkt(w, 0, 1'b1, "reset_mid");
        while (src_valid_o !== 1'b1 && c < 50) begin @(negedge clk); c++; end
        #2 srst = 1'b0;
        #1;
        total++;
        if (src_valid_o !== 1'b0 || snk_ready_o !== 1'b1 || src_data_o !== '0) begin
            bad++;
            $display("FAIL reset_mid {valid,ready}: got %b%b data %h want 01 data 0", src_valid_o, snk_ready_o, src_data_o);
        end
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        w.delete();
        w.push_back(64'd3); w.push_back(64'd1); w.push_back(64'd2);
        e.push_back(64'd1); e.push_back(64'd2); e.push_back(64'd3);
        send_pkt(w, 0, 1'b1, "after_reset");
        recv_pkt(e, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_descending();
        test_sorted();
        test_single();
        test_restart_drop();
        test_duplicates_backpressure();
        test_forced_eop();
        test_all_lengths();
        test_random_packets();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sorting.md
Name: sorting

Overview:
- Packet sorter on Avalon-ST-style sink and source interfaces.
- Buffers one packet of up to MAX_PKT_LEN words, sorts the words in ascending unsigned order, then streams the sorted packet out with start-of-packet and end-of-packet framing.
- Sits inline in a streaming datapath.
- Processes one packet at a time: no input is accepted while a packet is being sorted or sent.

Parameters:
- DWIDTH, 64: word width in bits.
- MAX_PKT_LEN, 128: maximum packet length in words (must be at least 2).

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  reset; asynchronous, active-low (0 = reset). The codebase port name is kept.
- snk_data_i  in  DWIDTH  input word.
- snk_startofpacket_i  in  1  first word of packet.
- snk_endofpacket_i  in  1  last word of packet.
- snk_valid_i  in  1  input word valid.
- snk_ready_o  out  1  block can accept input.
- src_data_o  out  DWIDTH  sorted output word.
- src_startofpacket_o  out  1  first sorted word.
- src_endofpacket_o  out  1  last sorted word.
- src_valid_o  out  1  output word valid.
- src_ready_i  in  1  downstream accepts the word.

Behaviour:
- Reset (srst_i=0, asynchronous):
  - State becomes IDLE.
  - snk_ready_o=1; src_valid_o=0; src_startofpacket_o=0; src_endofpacket_o=0; src_data_o=0.
  - Word count clears. Storage contents are don't-care.
  - Reset mid-operation abandons the packet.
- Storage: one memory of MAX_PKT_LEN x DWIDTH words. Count register width is $clog2(MAX_PKT_LEN+1).
- IDLE (snk_ready_o=1):
  - A beat with snk_valid_i=1 and snk_startofpacket_i=1 writes word 0 and sets count=1.
  - If the same beat has snk_endofpacket_i=1, go to SORT. Otherwise go to RECEIVE.
  - Valid beats without start-of-packet are dropped.
- RECEIVE (snk_ready_o=1):
  - Each valid beat writes storage[count] and increments count.
  - Cycles with snk_valid_i=0 are ignored; gaps of any length are legal.
  - A valid beat with endofpacket stores the word and goes to SORT.
  - A valid beat with startofpacket restarts the packet at index 0.
  - When count reaches MAX_PKT_LEN, the packet ends (forced end of packet) and the block goes to SORT.
- SORT (snk_ready_o=0):
  - In-place ascending unsigned sort over indices 0..N-1.
  - Method: bubble sort, or any equivalent method.
  - Each compare/swap step is at most 2 cycles.
  - Early exit is allowed when a pass makes no swap.
  - N=1 completes immediately.
  - Required bound: the first output word is valid within 2*N*N+2 cycles after the end-of-packet beat is accepted.
  - Then go to SEND.
- SEND (snk_ready_o=0):
  - Presents sorted words index 0..N-1 in order.
  - src_valid_o=1 continuously while words remain.
  - src_startofpacket_o=1 only on index 0; src_endofpacket_o=1 only on index N-1. For N=1 both are high on the same beat.
  - A word advances only when src_valid_o and src_ready_i are both 1.
  - When src_ready_i=0, data and flags hold stable.
  - With src_ready_i held at 1, one word is sent per cycle with no gaps.
  - After the endofpacket handshake: src_valid_o=0 on the next cycle and the block returns to IDLE with snk_ready_o=1 on that same cycle.
- Equal words are all preserved; duplicate values appear adjacent in the output.
- Output words are exactly the input multiset; nothing is lost or duplicated.
- All outputs are registered.

Test Plan:
- Reset, then send 10 words 10,9,...,1 with no gaps, src_ready_i=1:
  - Output is 1..10, one per cycle, sop on word 1, eop on word 10.
  - snk_ready_o=0 from after the input eop until output eop, then 1 again.
- Send already-sorted 0..9 -> output 0..9 unchanged, within 2*100+2 cycles of the input eop.
- Single-word packet 0xDEADBEEF (sop=eop=1) -> one output beat 0xDEADBEEF with sop=1, eop=1, valid=1.
- 100 packets of random length 1..MAX_PKT_LEN with random 64-bit data and 50% idle cycles on snk_valid_i:
  - Each output equals the sorted input.
  - snk_ready_o=1 on every cycle of input, including the cycle right after the previous output eop.
- Every length 1..128, random data, no gaps -> correct sorted output, eop only on the last beat, within the latency bound.
- Duplicates {5,5,0,FFFF_FFFF_FFFF_FFFF}:
  - Output 0,5,5,FFFF_FFFF_FFFF_FFFF (unsigned order).
  - Toggle src_ready_i low for 3 cycles mid-packet: data and flags hold stable, no word lost.
